// File: rtl/phy_mdio_pkg.sv
// Shared constants, types and helpers for the PHY MDIO bring-up and link-poll sequencer.
package phy_mdio_pkg;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_ANLPAR = 5'd5;
  localparam logic [4:0] REG_GBCR   = 5'd9;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [15:0] BMCR_VAL   = 16'h1340;
  localparam logic [15:0] GBCR_NO_1G = 16'h0000;
  localparam logic [15:0] GBCR_1G    = 16'h0300;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;

  typedef enum logic [2:0] {
    DELAY,
    WR_GBCR,
    WR_BMCR,
    POLL_WAIT,
    RD_BMSR,
    WAIT_BMSR,
    RD_ANLPAR,
    WAIT_ANLPAR
  } state_e;

  typedef struct packed {
    logic [4:0]  reg_addr;
    logic [1:0]  opcode;
    logic [15:0] data;
  } mdio_cmd_t;

  function automatic mdio_cmd_t mk_cmd(input logic [4:0] reg_addr, input logic [1:0] opcode,
                                       input logic [15:0] data);
    mdio_cmd_t c;
    c.reg_addr = reg_addr;
    c.opcode   = opcode;
    c.data     = data;
    return c;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/phy_mdio_seq.sv
// Configures an Ethernet PHY over an MDIO command interface, then polls BMSR/ANLPAR
// to report link state, resolved speed and duplex.
module phy_mdio_seq
  import phy_mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'h00,
  parameter int unsigned STARTUP_DELAY = 65535,
  parameter int unsigned POLL_INTERVAL = 1250000,
  parameter int unsigned RESP_TIMEOUT  = 4096,
  parameter bit          DISABLE_1G    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  input  logic        restart,
  output logic        cfg_done,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex,
  output logic        timeout_err
);

  localparam int unsigned CNT_MAX = max3(STARTUP_DELAY, POLL_INTERVAL, RESP_TIMEOUT);
  localparam int          CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] C_STARTUP = CNT_W'(STARTUP_DELAY);
  localparam logic [CNT_W-1:0] C_POLL    = CNT_W'(POLL_INTERVAL);
  localparam logic [CNT_W-1:0] C_RESP    = CNT_W'(RESP_TIMEOUT);

  localparam logic [15:0] GBCR_DATA = DISABLE_1G ? GBCR_NO_1G : GBCR_1G;

  localparam mdio_cmd_t CMD_RESET     = mk_cmd(REG_BMCR,   OP_WRITE, 16'h0000);
  localparam mdio_cmd_t CMD_GBCR      = mk_cmd(REG_GBCR,   OP_WRITE, GBCR_DATA);
  localparam mdio_cmd_t CMD_BMCR      = mk_cmd(REG_BMCR,   OP_WRITE, BMCR_VAL);
  localparam mdio_cmd_t CMD_RD_BMSR   = mk_cmd(REG_BMSR,   OP_READ,  16'h0000);
  localparam mdio_cmd_t CMD_RD_ANLPAR = mk_cmd(REG_ANLPAR, OP_READ,  16'h0000);

  state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_cmd_valid, w_cmd_valid_nxt;
  mdio_cmd_t       r_cmd, w_cmd_nxt;
  logic            r_cfg_done, w_cfg_done_nxt;
  logic            r_link_up, w_link_up_nxt;
  logic [1:0]      r_speed, w_speed_nxt;
  logic            r_full_duplex, w_full_duplex_nxt;
  logic            r_timeout_err, w_timeout_err_nxt;
  logic            r_restart_pend, w_restart_pend_nxt;

  logic w_in_wait;
  logic w_xfer;
  logic w_cnt_zero;
  logic w_restart_go;
  logic w_unused;

  assign w_in_wait  = (r_state == WAIT_BMSR) || (r_state == WAIT_ANLPAR);
  assign w_xfer     = r_cmd_valid && cmd_ready;
  assign w_cnt_zero = (r_cnt == '0);
  // A pending restart waits until no handshake is open and no read is outstanding.
  assign w_restart_go = r_restart_pend && !r_cmd_valid && !w_in_wait;
  assign w_unused     = ^{data_out[15:9], data_out[5:3], data_out[1:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_cmd_valid_nxt    = r_cmd_valid;
    w_cmd_nxt          = r_cmd;
    w_cfg_done_nxt     = r_cfg_done;
    w_link_up_nxt      = r_link_up;
    w_speed_nxt        = r_speed;
    w_full_duplex_nxt  = r_full_duplex;
    w_timeout_err_nxt  = r_timeout_err;
    w_restart_pend_nxt = r_restart_pend | restart;

    unique case (r_state)
      DELAY: begin
        if (w_cnt_zero) begin
          w_state_nxt     = WR_GBCR;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_GBCR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WR_GBCR: begin
        if (!r_cmd_valid) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_GBCR;
        end else if (w_xfer) begin
          w_cmd_valid_nxt = 1'b0;
          w_state_nxt     = WR_BMCR;
        end
      end
      WR_BMCR: begin
        if (!r_cmd_valid) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_BMCR;
        end else if (w_xfer) begin
          w_cmd_valid_nxt = 1'b0;
          w_cfg_done_nxt  = 1'b1;
          w_cnt_nxt       = C_POLL;
          w_state_nxt     = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt     = RD_BMSR;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_RD_BMSR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RD_BMSR: begin
        if (!r_cmd_valid) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_RD_BMSR;
        end else if (w_xfer) begin
          w_cmd_valid_nxt = 1'b0;
          w_cnt_nxt       = C_RESP;
          w_state_nxt     = WAIT_BMSR;
        end
      end
      WAIT_BMSR: begin
        if (data_out_valid) begin
          if (data_out[2]) begin
            w_link_up_nxt   = 1'b1;
            w_state_nxt     = RD_ANLPAR;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt       = CMD_RD_ANLPAR;
          end else begin
            w_link_up_nxt     = 1'b0;
            w_speed_nxt       = SPEED_10M;
            w_full_duplex_nxt = 1'b0;
            w_cnt_nxt         = C_POLL;
            w_state_nxt       = POLL_WAIT;
          end
        end else if (w_cnt_zero) begin
          w_timeout_err_nxt = 1'b1;
          w_link_up_nxt     = 1'b0;
          w_cnt_nxt         = C_POLL;
          w_state_nxt       = POLL_WAIT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RD_ANLPAR: begin
        if (!r_cmd_valid) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = CMD_RD_ANLPAR;
        end else if (w_xfer) begin
          w_cmd_valid_nxt = 1'b0;
          w_cnt_nxt       = C_RESP;
          w_state_nxt     = WAIT_ANLPAR;
        end
      end
      WAIT_ANLPAR: begin
        if (data_out_valid) begin
          // Highest common ability wins: 100FD, 100HD, 10FD, then 10HD.
          if (data_out[8]) begin
            w_speed_nxt       = SPEED_100M;
            w_full_duplex_nxt = 1'b1;
          end else if (data_out[7]) begin
            w_speed_nxt       = SPEED_100M;
            w_full_duplex_nxt = 1'b0;
          end else if (data_out[6]) begin
            w_speed_nxt       = SPEED_10M;
            w_full_duplex_nxt = 1'b1;
          end else begin
            w_speed_nxt       = SPEED_10M;
            w_full_duplex_nxt = 1'b0;
          end
          w_cnt_nxt   = C_POLL;
          w_state_nxt = POLL_WAIT;
        end else if (w_cnt_zero) begin
          w_timeout_err_nxt = 1'b1;
          w_link_up_nxt     = 1'b0;
          w_cnt_nxt         = C_POLL;
          w_state_nxt       = POLL_WAIT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
    endcase

    if (w_restart_go) begin
      w_state_nxt        = DELAY;
      w_cnt_nxt          = C_STARTUP;
      w_cmd_valid_nxt    = 1'b0;
      w_cfg_done_nxt     = 1'b0;
      w_link_up_nxt      = 1'b0;
      w_timeout_err_nxt  = 1'b0;
      w_restart_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= DELAY;
      r_cnt          <= C_STARTUP;
      r_cmd_valid    <= 1'b0;
      // NOTE: command fields are reset too, so cmd_* never shows X while cmd_valid is low.
      r_cmd          <= CMD_RESET;
      r_cfg_done     <= 1'b0;
      r_link_up      <= 1'b0;
      r_speed        <= SPEED_10M;
      r_full_duplex  <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_restart_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_cmd_valid    <= w_cmd_valid_nxt;
      r_cmd          <= w_cmd_nxt;
      r_cfg_done     <= w_cfg_done_nxt;
      r_link_up      <= w_link_up_nxt;
      r_speed        <= w_speed_nxt;
      r_full_duplex  <= w_full_duplex_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_restart_pend <= w_restart_pend_nxt;
    end
  end

  assign cmd_phy_addr   = PHY_ADDR;
  assign cmd_reg_addr   = r_cmd.reg_addr;
  assign cmd_data       = r_cmd.data;
  assign cmd_opcode     = r_cmd.opcode;
  assign cmd_valid      = r_cmd_valid;
  assign data_out_ready = w_in_wait;
  assign cfg_done       = r_cfg_done;
  assign link_up        = r_link_up;
  assign speed          = r_speed;
  assign full_duplex    = r_full_duplex;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_phy_mdio_seq.sv
// Scoreboard bench for phy_mdio_seq: expected commands queued by the stimulus,
// checked by a monitor on every handshake; a responder model answers reads.
module tb_phy_mdio_seq;
  import phy_mdio_pkg::*;

  localparam logic [4:0] TB_PHY = 5'h03;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        restart;
  logic        cfg_done;
  logic        link_up;
  logic [1:0]  speed;
  logic        full_duplex;
  logic        timeout_err;

  always #5 clk = ~clk;

  phy_mdio_seq #(
    .PHY_ADDR     (TB_PHY),
    .STARTUP_DELAY(10),
    .POLL_INTERVAL(30),
    .RESP_TIMEOUT (20),
    .DISABLE_1G   (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_phy_addr  (cmd_phy_addr),
    .cmd_reg_addr  (cmd_reg_addr),
    .cmd_data      (cmd_data),
    .cmd_opcode    (cmd_opcode),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .restart       (restart),
    .cfg_done      (cfg_done),
    .link_up       (link_up),
    .speed         (speed),
    .full_duplex   (full_duplex),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [4:0]  reg_addr;
    logic [1:0]  opcode;
    logic [15:0] data;
  } exp_cmd_t;

  typedef struct {
    bit          silent;
    int          delay;
    logic [15:0] data;
  } rsp_t;

  exp_cmd_t exp_q[$];
  rsp_t     rsp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  localparam int SIG_CFG = 0, SIG_LINK = 1, SIG_TMO = 2, SIG_VALID = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [15:0] d);
    exp_cmd_t e;
    e.reg_addr = r; e.opcode = OP_WRITE; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [4:0] r);
    exp_cmd_t e;
    e.reg_addr = r; e.opcode = OP_READ; e.data = 16'h0000;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input bit silent, input int delay, input logic [15:0] d);
    rsp_t r;
    r.silent = silent; r.delay = delay; r.data = d;
    rsp_q.push_back(r);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_CFG:  return cfg_done;
      SIG_LINK: return link_up;
      SIG_TMO:  return timeout_err;
      default:  return cmd_valid;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val, input string name);
    int k = 0;
    while (sig(sel) !== val && k < 300) begin step(); k++; end
    check(name, 32'(sig(sel)), 32'(val));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin step(); k++; end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_first_cmd(input string name);
    int k = 0;
    while (!cmd_valid && k < 100) begin step(); k++; end
    check(name, k, 11);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_valid"},   32'(cmd_valid),      0);
    check({tag, "_dout_ready"},  32'(data_out_ready), 0);
    check({tag, "_cfg_done"},    32'(cfg_done),       0);
    check({tag, "_link_up"},     32'(link_up),        0);
    check({tag, "_speed"},       32'(speed),          0);
    check({tag, "_duplex"},      32'(full_duplex),    0);
    check({tag, "_timeout"},     32'(timeout_err),    0);
    check({tag, "_reg_addr"},    32'(cmd_reg_addr),   0);
    check({tag, "_data"},        32'(cmd_data),       0);
    check({tag, "_opcode"},      32'(cmd_opcode),     32'(OP_WRITE));
  endtask

  // Monitor: every handshake must match the head of the expected-command queue.
  initial begin
    exp_cmd_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_cmd: got reg %0d op %b, expected no command",
                   cmd_reg_addr, cmd_opcode);
        end else begin
          e = exp_q.pop_front();
          check("cmd_reg",  32'(cmd_reg_addr), 32'(e.reg_addr));
          check("cmd_op",   32'(cmd_opcode),   32'(e.opcode));
          check("cmd_phy",  32'(cmd_phy_addr), 32'(TB_PHY));
          if (e.opcode == OP_WRITE) check("cmd_data", 32'(cmd_data), 32'(e.data));
        end
      end
    end
  end

  // Responder: answers each accepted read from rsp_q after the given delay.
  initial begin
    bit          pend;
    bit          acc;
    int          wcnt;
    logic [15:0] d;
    rsp_t        r;
    pend = 0; acc = 0; wcnt = 0; d = '0;
    data_out_valid = 1'b0;
    data_out       = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pend = 0; acc = 0;
        data_out_valid = 1'b0;
      end else begin
        if (acc) begin data_out_valid = 1'b0; acc = 0; end
        if (pend) begin
          if (wcnt > 0) wcnt--;
          else begin data_out_valid = 1'b1; data_out = d; pend = 0; end
        end
        if (data_out_valid && data_out_ready) acc = 1;
        if (cmd_valid && cmd_ready && cmd_opcode == OP_READ && rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          if (!r.silent) begin pend = 1; wcnt = r.delay; d = r.data; end
        end
      end
    end
  end

  initial begin
    logic [4:0]  h_reg;
    logic [1:0]  h_op;
    logic [15:0] h_data;
    int          bad;
    rst_n = 1'b0; cmd_ready = 1'b1; restart = 1'b0;
    step(); step();
    check_reset("rst0");

    // Bring-up with an always-ready master, then a 100M full-duplex link.
    push_wr(REG_GBCR, 16'h0000);
    push_wr(REG_BMCR, 16'h1340);
    push_rd(REG_BMSR);   push_rsp(0, 2, 16'h0004);
    push_rd(REG_ANLPAR); push_rsp(0, 1, 16'h0140);
    rst_n = 1'b1;
    wait_first_cmd("first_cmd_cycle");
    wait_until(SIG_CFG, 1'b1, "cfg_done_set");
    wait_drain("drain_first_poll");
    repeat (6) step();
    check("p1_link_up", 32'(link_up),     1);
    check("p1_speed",   32'(speed),       32'(SPEED_100M));
    check("p1_duplex",  32'(full_duplex), 1);

    push_rd(REG_BMSR); push_rsp(0, 0, 16'h0000);
    wait_until(SIG_LINK, 1'b0, "link_down");
    check("down_speed",  32'(speed),       32'(SPEED_10M));
    check("down_duplex", 32'(full_duplex), 0);
    cmd_ready = 1'b0;

    // Unanswered BMSR read: timeout, then polling continues.
    push_rd(REG_BMSR); push_rsp(1, 0, 16'h0000);
    push_rd(REG_BMSR); push_rsp(0, 0, 16'h0000);
    cmd_ready = 1'b1;
    wait_until(SIG_TMO, 1'b1, "timeout_set");
    check("timeout_link", 32'(link_up), 0);
    wait_drain("poll_after_timeout");
    cmd_ready = 1'b0;

    // Restart while a read is held: handshake completes before DELAY.
    wait_until(SIG_VALID, 1'b1, "rd_stalled");
    check("timeout_sticky", 32'(timeout_err), 1);
    restart = 1'b1; step(); restart = 1'b0;
    repeat (4) step();
    check("restart_deferred", 32'(cfg_done),  1);
    check("restart_hold_vld", 32'(cmd_valid), 1);
    push_rd(REG_BMSR); push_rsp(0, 0, 16'h0000);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    wait_until(SIG_CFG, 1'b0, "restart_cfg_clear");
    check("restart_tmo_clear", 32'(timeout_err), 0);
    check("restart_link",      32'(link_up),     0);

    // Master stalls the GBCR write for 20 cycles.
    wait_until(SIG_VALID, 1'b1, "gbcr_after_restart");
    check("gbcr_reg", 32'(cmd_reg_addr), 32'(REG_GBCR));
    h_reg = cmd_reg_addr; h_op = cmd_opcode; h_data = cmd_data; bad = 0;
    repeat (20) begin
      step();
      if (!cmd_valid || cmd_reg_addr !== h_reg || cmd_opcode !== h_op || cmd_data !== h_data)
        bad++;
    end
    check("stall_stable", bad, 0);
    push_wr(REG_GBCR, 16'h0000);
    push_wr(REG_BMCR, 16'h1340);
    cmd_ready = 1'b1;
    wait_until(SIG_CFG, 1'b1, "cfg_after_restart");
    cmd_ready = 1'b0;
    check("no_dup_write", exp_q.size(), 0);

    // Priority resolution: 10M FD, then 100M HD.
    push_rd(REG_BMSR);   push_rsp(0, 1, 16'h0004);
    push_rd(REG_ANLPAR); push_rsp(0, 0, 16'h0040);
    cmd_ready = 1'b1;
    wait_drain("drain_10fd");
    repeat (6) step();
    check("p10fd_link",   32'(link_up),     1);
    check("p10fd_speed",  32'(speed),       32'(SPEED_10M));
    check("p10fd_duplex", 32'(full_duplex), 1);
    push_rd(REG_BMSR);   push_rsp(0, 0, 16'h0006);
    push_rd(REG_ANLPAR); push_rsp(0, 3, 16'h0080);
    wait_drain("drain_100hd");
    repeat (8) step();
    check("p100hd_link",   32'(link_up),     1);
    check("p100hd_speed",  32'(speed),       32'(SPEED_100M));
    check("p100hd_duplex", 32'(full_duplex), 0);

    // Asynchronous reset while waiting for BMSR data.
    push_rd(REG_BMSR);
    wait_drain("rd_before_reset");
    repeat (3) step();
    check("dout_ready_in_wait", 32'(data_out_ready), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    step(); step();
    push_wr(REG_GBCR, 16'h0000);
    push_wr(REG_BMCR, 16'h1340);
    rst_n = 1'b1;
    wait_first_cmd("first_cmd_after_reset");
    wait_until(SIG_CFG, 1'b1, "cfg_after_reset");
    cmd_ready = 1'b0;
    repeat (5) step();
    check("sb_final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
